// File: rtl/wb_master_if.sv
// wb_master_if: groups the command, response and Wishbone signals of wb_master.
//   master modport : the wb_master view (takes commands, drives the bus, returns responses).
//   slave modport  : the environment view (issues commands, plays the Wishbone slave).
// Parameters AWIDTH/DWIDTH set the address and data widths; byte lanes = DWIDTH/8.
interface wb_master_if #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 32
);
    localparam int SELW = DWIDTH / 8;

    // command port
    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_we;
    logic [AWIDTH-1:0] i_req_addr;
    logic [DWIDTH-1:0] i_req_data;
    logic [SELW-1:0]   i_req_sel;

    // response port
    logic              o_rsp_valid;
    logic [DWIDTH-1:0] o_rsp_data;
    logic              o_rsp_err;

    // Wishbone B4 pipelined bus
    logic              o_wb_cyc;
    logic              o_wb_stb;
    logic              o_wb_we;
    logic [AWIDTH-1:0] o_wb_addr;
    logic [DWIDTH-1:0] o_wb_data;
    logic [SELW-1:0]   o_wb_sel;
    logic [DWIDTH-1:0] i_wb_read_data;
    logic              i_wb_ack;
    logic              i_wb_stall;

    modport master (
        input  i_req_valid, i_req_we, i_req_addr, i_req_data, i_req_sel,
        output o_req_ready,
        output o_rsp_valid, o_rsp_data, o_rsp_err,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        input  i_wb_read_data, i_wb_ack, i_wb_stall
    );

    modport slave (
        output i_req_valid, i_req_we, i_req_addr, i_req_data, i_req_sel,
        input  o_req_ready,
        input  o_rsp_valid, o_rsp_data, o_rsp_err,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        output i_wb_read_data, i_wb_ack, i_wb_stall
    );
endinterface

// File: rtl/wb_master.sv
// wb_master: single-outstanding Wishbone B4 pipelined initiator.
// Accepts one load/store command on a valid/ready port, runs one bus cycle,
// and returns read data (or a timeout error) on a one-cycle response pulse.
// Ports:
//   m_clk : clock, rising edge
//   m_rst : asynchronous active-low reset
//   bus   : wb_master_if.master (command, response and Wishbone signals)
// Parameters: AWIDTH address width, DWIDTH data width,
//             TIMEOUT cycles from bus request to ack before an error (>= 2).
module wb_master #(
    parameter int AWIDTH  = 5,
    parameter int DWIDTH  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic        m_clk,
    input  logic        m_rst,
    wb_master_if.master bus
);
    localparam int SELW = DWIDTH / 8;
    localparam int CW   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              ack_ok;
    logic              expired;
    logic [CW-1:0]     tmo_cnt;

    logic              cyc;
    logic              stb;
    logic              we;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] wdata;
    logic [SELW-1:0]   sel;
    logic              rsp_valid;
    logic [DWIDTH-1:0] rsp_data;
    logic              rsp_err;

    assign expired = (tmo_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge m_clk or negedge m_rst) begin
        if (!m_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // An ack only counts in REQ once the strobe is taken (stall low), or in WAIT.
    // An ack arriving together with the timeout still yields a normal response.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ack_ok    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_req_valid) begin
                    accept    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (!bus.i_wb_stall && bus.i_wb_ack) begin
                    ack_ok    = 1'b1;
                    state_nxt = RESP;
                end else if (expired) begin
                    state_nxt = RESP;
                end else if (!bus.i_wb_stall) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.i_wb_ack) begin
                    ack_ok    = 1'b1;
                    state_nxt = RESP;
                end else if (expired) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus and response outputs are flops loaded from the next state, so they
    // line up with the state register without any combinational path from inputs.
    always_ff @(posedge m_clk or negedge m_rst) begin
        if (!m_rst) begin
            cyc       <= 1'b0;
            stb       <= 1'b0;
            rsp_valid <= 1'b0;
            tmo_cnt   <= '0;
            we        <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            sel       <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            cyc       <= (state_nxt == REQ) || (state_nxt == WAIT);
            stb       <= (state_nxt == REQ);
            rsp_valid <= (state_nxt == RESP);

            if (accept) begin
                tmo_cnt <= '0;
                we      <= bus.i_req_we;
                addr    <= bus.i_req_addr;
                wdata   <= bus.i_req_data;
                sel     <= bus.i_req_sel;
            end else if ((state == REQ) || (state == WAIT)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (ack_ok) begin
                rsp_data <= we ? '0 : bus.i_wb_read_data;
                rsp_err  <= 1'b0;
            end else if (state_nxt == RESP) begin
                // only reachable from REQ/WAIT without an ack: the cycle timed out
                rsp_data <= '0;
                rsp_err  <= 1'b1;
            end
        end
    end

    assign bus.o_req_ready = (state == IDLE);
    assign bus.o_rsp_valid = rsp_valid;
    assign bus.o_rsp_data  = rsp_data;
    assign bus.o_rsp_err   = rsp_err;
    assign bus.o_wb_cyc    = cyc;
    assign bus.o_wb_stb    = stb;
    assign bus.o_wb_we     = we;
    assign bus.o_wb_addr   = addr;
    assign bus.o_wb_data   = wdata;
    assign bus.o_wb_sel    = sel;
endmodule

// File: tb/tb_wb_master.sv
// tb_wb_master: self-checking bench for wb_master.
// A behavioural Wishbone memory slave (configurable stall, ack delay, zero-wait
// ack, ack suppression, stray ack) answers the bus; expected responses and
// latencies come from a word-level memory model and the protocol timing rules.
`timescale 1ns/1ps
module tb_wb_master;
    localparam int AW  = 5;
    localparam int DW  = 32;
    localparam int TMO = 16;
    localparam int NW  = 1 << AW;

    logic m_clk = 1'b0;
    logic m_rst = 1'b0;
    always #5 m_clk = ~m_clk;

    wb_master_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    wb_master #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TMO)) dut (
        .m_clk (m_clk),
        .m_rst (m_rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // reference model memory
    logic [DW-1:0] model_mem [NW];

    // slave configuration and state
    int            stall_cfg = 0;
    int            delay_cfg = 0;
    bit            zw_cfg    = 1'b0;
    bit            ack_en    = 1'b1;
    bit            stray_req = 1'b0;
    int            stall_left = 0;
    int            ack_cnt    = 0;
    bit            in_req     = 1'b0;
    logic [DW-1:0] rd_latched = '0;
    logic [DW-1:0] smem [NW];

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [3:0] s);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Wishbone slave: decides stall/ack at the falling edge for the next rising edge.
    always @(negedge m_clk) begin
        bus.i_wb_ack   = 1'b0;
        bus.i_wb_stall = 1'b0;
        if (!m_rst) begin
            ack_cnt    = 0;
            stall_left = 0;
            in_req     = 1'b0;
        end else begin
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) begin
                    bus.i_wb_ack       = 1'b1;
                    bus.i_wb_read_data = rd_latched;
                end
            end
            if (stray_req) begin
                bus.i_wb_ack       = 1'b1;
                bus.i_wb_read_data = 32'hDEADBEEF;
                stray_req          = 1'b0;
            end
            if (bus.o_wb_cyc && bus.o_wb_stb) begin
                if (!in_req) begin
                    stall_left = stall_cfg;
                    in_req     = 1'b1;
                end
                if (stall_left > 0) begin
                    bus.i_wb_stall = 1'b1;
                    stall_left--;
                end else begin
                    in_req = 1'b0;
                    if (bus.o_wb_we)
                        smem[bus.o_wb_addr] = merge(smem[bus.o_wb_addr], bus.o_wb_data, bus.o_wb_sel);
                    rd_latched = smem[bus.o_wb_addr];
                    if (ack_en) begin
                        if (zw_cfg) begin
                            bus.i_wb_ack       = 1'b1;
                            bus.i_wb_read_data = rd_latched;
                        end else begin
                            ack_cnt = delay_cfg + 1;
                        end
                    end
                end
            end else begin
                in_req = 1'b0;
            end
        end
    end

    // Issue one command (caller sits just after a falling edge) and observe its response.
    // lat counts cycles after the accepting edge up to the cycle holding o_rsp_valid.
    task automatic issue(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [3:0] sel, output int lat, output logic [DW-1:0] rdata,
                         output logic err, output bit got, output int stb_cyc,
                         output bit stable, output bit cyc_at_rsp);
        int n;
        n = 0;
        while (!bus.o_req_ready && n < 64) begin
            @(negedge m_clk);
            n++;
        end
        bus.i_req_valid = 1'b1;
        bus.i_req_we    = we;
        bus.i_req_addr  = addr;
        bus.i_req_data  = data;
        bus.i_req_sel   = sel;
        @(posedge m_clk);
        #1;
        bus.i_req_valid = 1'b0;
        lat = 0; got = 1'b0; stb_cyc = 0; stable = 1'b1; cyc_at_rsp = 1'b1;
        rdata = 'x; err = 1'bx;
        for (int i = 1; i <= 64 && !got; i++) begin
            @(negedge m_clk);
            lat = i;
            if (bus.o_wb_stb) stb_cyc++;
            if (bus.o_wb_addr !== addr || bus.o_wb_data !== data ||
                bus.o_wb_sel !== sel || bus.o_wb_we !== we) stable = 1'b0;
            if (bus.o_rsp_valid) begin
                got        = 1'b1;
                rdata      = bus.o_rsp_data;
                err        = bus.o_rsp_err;
                cyc_at_rsp = bus.o_wb_cyc;
            end
        end
    endtask

    task automatic slave_default();
        stall_cfg = 0; delay_cfg = 0; zw_cfg = 1'b0; ack_en = 1'b1;
    endtask

    task automatic test_reset();
        m_rst = 1'b0;
        repeat (2) @(negedge m_clk);
        checks++;
        if (bus.o_req_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b want=1", bus.o_req_ready);
        end
        checks++;
        if ({bus.o_rsp_valid, bus.o_rsp_err, bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=00000",
                     {bus.o_rsp_valid, bus.o_rsp_err, bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we});
        end
        checks++;
        if ({bus.o_rsp_data, bus.o_wb_data, bus.o_wb_addr, bus.o_wb_sel} !== '0) begin
            failures++;
            $display("FAIL reset_data got rsp=%h wdata=%h addr=%h sel=%h want all 0",
                     bus.o_rsp_data, bus.o_wb_data, bus.o_wb_addr, bus.o_wb_sel);
        end
        #2 m_rst = 1'b1;
        @(negedge m_clk);
    endtask

    task automatic test_write_read();
        int lat; logic [DW-1:0] rd; logic er; bit got; int sc; bit st; bit cr;
        slave_default();
        issue(1'b1, 5'd5, 32'h0000000A, 4'hF, lat, rd, er, got, sc, st, cr);
        model_mem[5] = merge(model_mem[5], 32'h0000000A, 4'hF);
        checks++;
        if (!got || er !== 1'b0 || rd !== 32'h0) begin
            failures++; $display("FAIL wr_rsp got=%0b err=%b data=%h want got=1 err=0 data=0", got, er, rd);
        end
        checks++;
        if (lat != 3) begin failures++; $display("FAIL wr_latency got=%0d want=3", lat); end
        issue(1'b0, 5'd5, 32'h0, 4'hF, lat, rd, er, got, sc, st, cr);
        checks++;
        if (!got || er !== 1'b0 || rd !== 32'h0000000A) begin
            failures++; $display("FAIL rd_rsp got=%0b err=%b data=%h want data=0000000a", got, er, rd);
        end
        checks++;
        if (lat != 3) begin failures++; $display("FAIL rd_latency got=%0d want=3", lat); end
    endtask

    task automatic test_byte_lanes();
        int lat; logic [DW-1:0] rd; logic er; bit got; int sc; bit st; bit cr;
        slave_default();
        issue(1'b1, 5'd3, 32'hAABBCCDD, 4'hF, lat, rd, er, got, sc, st, cr);
        model_mem[3] = merge(model_mem[3], 32'hAABBCCDD, 4'hF);
        issue(1'b1, 5'd3, 32'h11223344, 4'b0011, lat, rd, er, got, sc, st, cr);
        model_mem[3] = merge(model_mem[3], 32'h11223344, 4'b0011);
        issue(1'b0, 5'd3, 32'h0, 4'hF, lat, rd, er, got, sc, st, cr);
        checks++;
        if (!got || rd !== 32'hAABB3344) begin
            failures++; $display("FAIL byte_lanes got=%h want=aabb3344", rd);
        end
    endtask

    task automatic test_stall();
        int lat; logic [DW-1:0] rd; logic er; bit got; int sc; bit st; bit cr;
        logic [DW-1:0] d;
        slave_default();
        stall_cfg = 3;
        d = $urandom;
        issue(1'b1, 5'd7, d, 4'hF, lat, rd, er, got, sc, st, cr);
        model_mem[7] = d;
        checks++;
        if (sc != 4) begin failures++; $display("FAIL stall_stb_cycles got=%0d want=4", sc); end
        checks++;
        if (!st) begin failures++; $display("FAIL stall_hold got=unstable want=stable"); end
        checks++;
        if (!got || lat != 6 || er !== 1'b0) begin
            failures++; $display("FAIL stall_latency got=%0d err=%b want=6 err=0", lat, er);
        end
        slave_default();
    endtask

    task automatic test_zero_wait();
        int lat; logic [DW-1:0] rd; logic er; bit got; int sc; bit st; bit cr;
        slave_default();
        zw_cfg = 1'b1;
        issue(1'b0, 5'd7, 32'h0, 4'hF, lat, rd, er, got, sc, st, cr);
        checks++;
        if (!got || lat != 2 || rd !== model_mem[7]) begin
            failures++; $display("FAIL zero_wait got lat=%0d data=%h want lat=2 data=%h", lat, rd, model_mem[7]);
        end
        slave_default();
    endtask

    task automatic test_timeout();
        int lat; logic [DW-1:0] rd; logic er; bit got; int sc; bit st; bit cr;
        slave_default();
        ack_en = 1'b0;
        issue(1'b0, 5'd2, 32'h0, 4'hF, lat, rd, er, got, sc, st, cr);
        checks++;
        if (!got || lat != TMO + 1) begin
            failures++; $display("FAIL timeout_latency got=%0d want=%0d", lat, TMO + 1);
        end
        checks++;
        if (er !== 1'b1 || rd !== 32'h0 || cr !== 1'b0) begin
            failures++; $display("FAIL timeout_rsp got err=%b data=%h cyc=%b want err=1 data=0 cyc=0", er, rd, cr);
        end
        @(negedge m_clk);
        checks++;
        if (bus.o_req_ready !== 1'b1) begin
            failures++; $display("FAIL timeout_ready got=%b want=1", bus.o_req_ready);
        end
        // ack lands in the very cycle the counter expires: ack wins
        slave_default();
        delay_cfg = TMO - 2;
        issue(1'b0, 5'd5, 32'h0, 4'hF, lat, rd, er, got, sc, st, cr);
        checks++;
        if (!got || lat != TMO + 1 || er !== 1'b0 || rd !== model_mem[5]) begin
            failures++; $display("FAIL ack_at_timeout got lat=%0d err=%b data=%h want lat=%0d err=0 data=%h",
                                 lat, er, rd, TMO + 1, model_mem[5]);
        end
        // ack one cycle too late: error, and the late ack falls in RESP and is dropped
        delay_cfg = TMO - 1;
        issue(1'b0, 5'd5, 32'h0, 4'hF, lat, rd, er, got, sc, st, cr);
        checks++;
        if (!got || lat != TMO + 1 || er !== 1'b1 || rd !== 32'h0) begin
            failures++; $display("FAIL ack_late got lat=%0d err=%b data=%h want lat=%0d err=1 data=0",
                                 lat, er, rd, TMO + 1);
        end
        slave_default();
        issue(1'b0, 5'd5, 32'h0, 4'hF, lat, rd, er, got, sc, st, cr);
        checks++;
        if (!got || lat != 3 || er !== 1'b0 || rd !== model_mem[5]) begin
            failures++; $display("FAIL after_late_ack got lat=%0d err=%b data=%h want lat=3 err=0 data=%h",
                                 lat, er, rd, model_mem[5]);
        end
        // slave stalls forever: stb stays up for the whole timeout window
        stall_cfg = 40;
        issue(1'b0, 5'd1, 32'h0, 4'hF, lat, rd, er, got, sc, st, cr);
        checks++;
        if (!got || lat != TMO + 1 || er !== 1'b1 || sc != TMO) begin
            failures++; $display("FAIL stall_timeout got lat=%0d err=%b stb=%0d want lat=%0d err=1 stb=%0d",
                                 lat, er, sc, TMO + 1, TMO);
        end
        slave_default();
        @(negedge m_clk);
    endtask

    task automatic test_reset_mid_wait();
        int lat; logic [DW-1:0] rd; logic er; bit got; int sc; bit st; bit cr;
        bit seen; int pulses;
        slave_default();
        delay_cfg = 5;
        seen = 1'b0;
        bus.i_req_valid = 1'b1; bus.i_req_we = 1'b0; bus.i_req_addr = 5'd9; bus.i_req_sel = 4'hF;
        @(posedge m_clk);
        #1 bus.i_req_valid = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge m_clk);
            if (bus.o_wb_cyc && !bus.o_wb_stb) seen = 1'b1;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL reach_wait got=no_wait want=wait"); end
        #2 m_rst = 1'b0;
        #1;
        checks++;
        if (bus.o_wb_cyc !== 1'b0 || bus.o_wb_stb !== 1'b0 || bus.o_req_ready !== 1'b1 || bus.o_rsp_valid !== 1'b0) begin
            failures++; $display("FAIL reset_abort got cyc=%b stb=%b ready=%b rsp=%b want 0 0 1 0",
                                 bus.o_wb_cyc, bus.o_wb_stb, bus.o_req_ready, bus.o_rsp_valid);
        end
        pulses = 0;
        repeat (2) @(negedge m_clk);
        #2 m_rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge m_clk);
            if (bus.o_rsp_valid) pulses++;
        end
        checks++;
        if (pulses != 0) begin failures++; $display("FAIL reset_no_rsp got=%0d want=0", pulses); end
        slave_default();
        issue(1'b0, 5'd5, 32'h0, 4'hF, lat, rd, er, got, sc, st, cr);
        checks++;
        if (!got || lat != 3 || er !== 1'b0 || rd !== model_mem[5]) begin
            failures++; $display("FAIL post_reset_read got lat=%0d err=%b data=%h want lat=3 err=0 data=%h",
                                 lat, er, rd, model_mem[5]);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [DW-1:0] rd; logic er; bit got; int sc; bit st; bit cr;
        int rsp_cyc[4]; logic [DW-1:0] rsp_dat[4]; int nrsp; int idx; int stray_rsp;
        logic [DW-1:0] d;
        slave_default();
        for (int a = 0; a < 4; a++) begin
            d = $urandom;
            issue(1'b1, AW'(a), d, 4'hF, lat, rd, er, got, sc, st, cr);
            model_mem[a] = d;
        end
        nrsp = 0; idx = 0;
        bus.i_req_valid = 1'b1; bus.i_req_we = 1'b0; bus.i_req_addr = 5'd0; bus.i_req_sel = 4'hF;
        for (int c = 1; c <= 30; c++) begin
            @(negedge m_clk);
            if (bus.o_rsp_valid) begin
                if (nrsp < 4) begin rsp_cyc[nrsp] = c; rsp_dat[nrsp] = bus.o_rsp_data; end
                nrsp++;
            end
            if (bus.i_req_valid && bus.o_req_ready) begin
                @(posedge m_clk);
                #1;
                idx++;
                if (idx < 4) bus.i_req_addr = AW'(idx);
                else bus.i_req_valid = 1'b0;
            end
        end
        checks++;
        if (nrsp != 4) begin failures++; $display("FAIL b2b_count got=%0d want=4", nrsp); end
        for (int i = 0; i < 4 && i < nrsp; i++) begin
            checks++;
            if (rsp_dat[i] !== model_mem[i]) begin
                failures++; $display("FAIL b2b_data%0d got=%h want=%h", i, rsp_dat[i], model_mem[i]);
            end
            if (i > 0) begin
                checks++;
                if (rsp_cyc[i] - rsp_cyc[i-1] != 4) begin
                    failures++; $display("FAIL b2b_spacing%0d got=%0d want=4", i, rsp_cyc[i] - rsp_cyc[i-1]);
                end
            end
        end
        stray_rsp = 0;
        stray_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge m_clk);
            if (bus.o_rsp_valid || bus.o_wb_cyc || !bus.o_req_ready) stray_rsp++;
        end
        checks++;
        if (stray_rsp != 0) begin failures++; $display("FAIL stray_ack got=%0d want=0", stray_rsp); end
    endtask

    task automatic test_random();
        int lat; logic [DW-1:0] rd; logic er; bit got; int sc; bit st; bit cr;
        bit we; logic [AW-1:0] a; logic [DW-1:0] d; logic [3:0] s;
        logic [DW-1:0] exp_d; int exp_lat;
        for (int n = 0; n < 40; n++) begin
            we        = 1'($urandom_range(0, 1));
            a         = AW'($urandom_range(0, NW - 1));
            d         = $urandom;
            s         = 4'($urandom_range(0, 15));
            stall_cfg = $urandom_range(0, 2);
            delay_cfg = $urandom_range(0, 3);
            zw_cfg    = 1'($urandom_range(0, 1));
            ack_en    = 1'b1;
            exp_lat   = zw_cfg ? 2 + stall_cfg : 3 + stall_cfg + delay_cfg;
            if (we) begin
                model_mem[a] = merge(model_mem[a], d, s);
                exp_d = '0;
            end else begin
                exp_d = model_mem[a];
            end
            issue(we, a, d, s, lat, rd, er, got, sc, st, cr);
            checks++;
            if (!got || lat != exp_lat) begin
                failures++; $display("FAIL rnd%0d_latency got=%0d want=%0d", n, lat, exp_lat);
            end
            checks++;
            if (rd !== exp_d || er !== 1'b0) begin
                failures++; $display("FAIL rnd%0d_rsp got data=%h err=%b want data=%h err=0", n, rd, er, exp_d);
            end
        end
        slave_default();
    endtask

    initial begin
        bus.i_req_valid = 1'b0;
        bus.i_req_we    = 1'b0;
        bus.i_req_addr  = '0;
        bus.i_req_data  = '0;
        bus.i_req_sel   = '0;
        for (int i = 0; i < NW; i++) begin
            model_mem[i] = '0;
            smem[i]      = '0;
        end
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_stall();
        test_zero_wait();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=stuck want=finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/wb_master.md
# wb_master

Single-outstanding Wishbone B4 pipelined initiator that drives the `memory` slave (cyc/stb/we/addr/data/sel, with ack/stall). It accepts one load/store command on a valid/ready request port and drives the bus transaction. It then returns read data, or a timeout error, on a one-cycle response pulse. It sits between the core's load/store path and the memory slave, and is the bus-facing counterpart of that slave.

## Interface
- AWIDTH, 5, address width; matches the slave
- DWIDTH, 32, data width; byte lanes = DWIDTH/8 = 4
- TIMEOUT, 16, cycles allowed from bus request to ack before the error response; must be ≥ 2
- m_clk  in  1  clock; all logic is rising-edge
- m_rst  in  1  asynchronous, active-low reset
- i_req_valid  in  1  command present
- o_req_ready  out  1  master can accept a command
- i_req_we  in  1  1 = write, 0 = read
- i_req_addr  in  AWIDTH  word address
- i_req_data  in  DWIDTH  write data
- i_req_sel  in  4  byte enables
- o_rsp_valid  out  1  one-cycle response pulse
- o_rsp_data  out  DWIDTH  read data; 0 for writes and errors
- o_rsp_err  out  1  timeout flag; valid with o_rsp_valid
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  bus controls
- o_wb_addr  out  AWIDTH  bus address
- o_wb_data  out  DWIDTH  bus write data
- o_wb_sel  out  4  bus byte enables
- i_wb_read_data  in  DWIDTH  slave read data
- i_wb_ack  in  1  slave acknowledge
- i_wb_stall  in  1  slave cannot take stb this cycle

## Operation
- **FSM states:** IDLE, REQ, WAIT, RESP.
- **Outputs by state:**
  - IDLE: o_req_ready = 1; o_wb_cyc = 0, o_wb_stb = 0.
  - REQ: o_wb_cyc = 1, o_wb_stb = 1.
  - WAIT: o_wb_cyc = 1, o_wb_stb = 0.
  - RESP: o_rsp_valid = 1, o_wb_cyc = 0.
- **Outputs are registered:** o_wb_* and o_rsp_* are driven from flops, not combinationally from inputs. o_req_ready decodes the state register.
- **Command capture:** in IDLE, when i_req_valid is 1, we/addr/data/sel are latched into the o_wb_* registers and the FSM goes to REQ.
- **Address/data hold:** o_wb_addr, o_wb_data, o_wb_sel and o_wb_we hold their values until the next command is accepted.
- **REQ:**
  - If i_wb_stall = 1, stay in REQ with stb held high.
  - If i_wb_stall = 0, the strobe is accepted. Go to WAIT, or straight to RESP if i_wb_ack is also 1 in that cycle.
- **WAIT:** i_wb_ack = 1 moves the FSM to RESP.
- **Ack capture:** on the accepted ack, a read latches i_wb_read_data into o_rsp_data. A write clears o_rsp_data to 0. o_rsp_err is cleared to 0.
- **Timeout:**
  - An $clog2(TIMEOUT+1)-bit counter clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT-1 without an ack, the FSM goes to RESP with o_rsp_err = 1 and o_rsp_data = 0. This drops cyc and abandons the cycle.
  - An ack in the same cycle as the timeout wins: normal response, err = 0.
- **RESP:** lasts exactly one cycle, then IDLE. The next command can only be accepted in IDLE.
- **Stray ack:** an i_wb_ack seen in IDLE or RESP is ignored.
- **Reset:** asynchronous assertion mid-transaction forces IDLE immediately and drops cyc/stb. No response is issued for the aborted command.

## Timing
- **Reset values:** state IDLE; o_req_ready = 1. All other outputs are 0: o_rsp_valid, o_rsp_data, o_rsp_err, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel.
- **Minimum latency** (no stall, slave acks the cycle after stb is accepted), with edge k being the edge that accepts the command:
  - cyc/stb high during cycle k+1.
  - ack sampled at edge k+2.
  - o_rsp_valid high during cycle k+3.
  - The next command is accepted at edge k+4.
  - Command-to-response is 3 cycles; issue-to-issue period is 4 cycles.
- **Stall:** each stall cycle adds one cycle, with stb held high throughout.
- **Zero-wait ack** (ack with stall = 0 in REQ): o_rsp_valid is high 2 cycles after acceptance.
- **Error response:** o_rsp_valid with err = 1 occurs at cycle k+1+TIMEOUT.

## Test plan
- **Write then read:** write addr 5, data 32'h0000000A, sel 4'hF; then read addr 5. Required: write rsp err = 0, data 0. Read rsp data = 32'h0000000A with 3-cycle latency.
- **Byte lanes:** write 32'hAABBCCDD to addr 3 with sel 4'hF, then 32'h11223344 with sel 4'b0011, then read addr 3. Required: read data = 32'hAABB3344.
- **Stall:** hold i_wb_stall = 1 for 3 cycles from REQ entry. Required: stb stays high 4 cycles; o_wb_addr/data stay stable throughout; response 3 cycles later than nominal.
- **Timeout:** with TIMEOUT = 16 and the slave never acking, issue a read. Required: o_rsp_valid with err = 1 and data 0 at cycle k+17; cyc low in that cycle; o_req_ready = 1 on the next cycle.
- **Reset mid-WAIT:** pull m_rst low while in WAIT. Required: cyc/stb go to 0 immediately, no rsp pulse, o_req_ready = 1. After release, a read of addr 5 completes normally.
- **Back-to-back:** hold i_req_valid high for 4 reads (addr 0..3). Required: exactly 4 rsp pulses spaced 4 cycles apart; a stray ack in IDLE produces no response.
